// File: rtl/sb_pkg.sv
// Shared types, constants and helpers for the coalescing store buffer.
package sb_pkg;

  function automatic int unsigned sb_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  localparam int unsigned SB_AW = 32;
  localparam int unsigned SB_DW = 32;
  localparam int unsigned SB_BE = SB_DW / 8;
  localparam int unsigned OFF   = sb_clog2(SB_BE);

  typedef struct packed {
    logic [SB_AW-OFF-1:0] waddr;
    logic [SB_DW-1:0]     data;
    logic [SB_BE-1:0]     be;
  } sb_entry_t;

endpackage

// File: rtl/sb_byte_forward.sv
// One byte lane of load forwarding: the youngest selected entry wins, scanning oldest to youngest from head.
module sb_byte_forward
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = sb_clog2(DEPTH)
) (
  input  logic [PW-1:0]         head,
  input  logic [DEPTH-1:0]      sel,
  input  logic [DEPTH-1:0][7:0] lane,
  output logic                  hit_c,
  output logic [7:0]            byte_c
);

  logic [PW-1:0] idx;

  always_comb begin
    hit_c  = 1'b0;
    byte_c = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (sel[idx]) begin
        hit_c  = 1'b1;
        byte_c = lane[idx];
      end
    end
  end

endmodule

// File: rtl/coalescing_store_buffer.sv
// N-entry in-order store buffer with byte-granular load forwarding and valid/ready drain.
// Define SB_COALESCE_EN to merge stores into the youngest matching non-head entry.
module coalescing_store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic [AW-1:0]            enq_addr,
  input  logic [DW-1:0]            enq_data,
  input  logic [DW/8-1:0]          enq_byte_en,
  output logic                     enq_ready,
  input  logic                     lk_valid,
  input  logic [AW-1:0]            lk_addr,
  output logic                     lk_hit,
  output logic [DW-1:0]            lk_data,
  output logic [DW/8-1:0]          lk_byte_en,
  output logic                     drain_valid,
  output logic [AW-1:0]            drain_addr,
  output logic [DW-1:0]            drain_data,
  output logic [DW/8-1:0]          drain_byte_en,
  input  logic                     drain_ready,
  output logic                     full,
  output logic                     empty,
  output logic [sb_clog2(DEPTH):0] count,
  output logic                     stall_pipeline
);

  localparam int unsigned BE   = DW / 8;
  localparam int unsigned WOFF = (DW == SB_DW) ? OFF : sb_clog2(BE);
  localparam int unsigned WAW  = AW - WOFF;
  localparam int unsigned PW   = sb_clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;

  typedef struct packed {
    logic [WAW-1:0] waddr;
    logic [DW-1:0]  data;
    logic [BE-1:0]  be;
  } entry_t;

  entry_t         ent_q [DEPTH];
  entry_t         ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [WAW-1:0] enq_waddr, lk_waddr;
  logic           coalesce_hit;
  logic [PW-1:0]  coal_idx;
  logic           push, pop, coal_wr;
  logic [DEPTH-1:0] lk_match;

  assign enq_waddr = enq_addr[AW-1:WOFF];
  assign lk_waddr  = lk_addr[AW-1:WOFF];

  if (WOFF > 0) begin : g_unused
    logic unused_low_bits;
    assign unused_low_bits = ^{enq_addr[WOFF-1:0], lk_addr[WOFF-1:0]};
  end

  assign full           = (cnt_q == CW'(DEPTH));
  assign empty          = (cnt_q == '0);
  assign count          = cnt_q;
  assign enq_ready      = !full || coalesce_hit;
  assign stall_pipeline = enq_valid && !enq_ready;
  assign drain_valid    = !empty;

  assign pop     = drain_valid && drain_ready;
  assign coal_wr = enq_valid && coalesce_hit;
  assign push    = enq_valid && enq_ready && !coalesce_hit && (|enq_byte_en);

`ifdef SB_COALESCE_EN
  // Youngest valid entry with the same word address; merging into the head is disallowed.
  logic          coal_found;
  logic [PW-1:0] coal_scan;

  always_comb begin
    coal_found = 1'b0;
    coal_idx   = '0;
    coal_scan  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      coal_scan = head_q + PW'(k);
      if (vld_q[coal_scan] && (ent_q[coal_scan].waddr == enq_waddr)) begin
        coal_found = 1'b1;
        coal_idx   = coal_scan;
      end
    end
    coalesce_hit = coal_found && (coal_idx != head_q);
  end
`else
  assign coalesce_hit = 1'b0;
  assign coal_idx     = '0;
`endif

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    if (coal_wr) begin
      for (int unsigned b = 0; b < BE; b++) begin
        if (enq_byte_en[b]) ent_d[coal_idx].data[8*b +: 8] = enq_data[8*b +: 8];
      end
      ent_d[coal_idx].be = ent_q[coal_idx].be | enq_byte_en;
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    if (push) begin
      ent_d[tail_q] = '{waddr: enq_waddr, data: enq_data, be: enq_byte_en};
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // Payload needs no reset: every reader is qualified by a valid bit or empty.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign drain_addr    = empty ? '0 : (AW'(ent_q[head_q].waddr) << WOFF);
  assign drain_data    = empty ? '0 : ent_q[head_q].data;
  assign drain_byte_en = empty ? '0 : ent_q[head_q].be;

  always_comb begin
    lk_match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_match[i] = lk_valid && vld_q[i] && (ent_q[i].waddr == lk_waddr);
    end
  end

  for (genvar b = 0; b < BE; b++) begin : g_fwd
    logic [DEPTH-1:0]      sel;
    logic [DEPTH-1:0][7:0] lane;

    always_comb begin
      sel  = '0;
      lane = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sel[i]  = lk_match[i] && ent_q[i].be[b];
        lane[i] = ent_q[i].data[8*b +: 8];
      end
    end

    sb_byte_forward #(
      .DEPTH (DEPTH),
      .PW    (PW)
    ) u_fwd (
      .head   (head_q),
      .sel    (sel),
      .lane   (lane),
      .hit_c  (lk_byte_en[b]),
      .byte_c (lk_data[8*b +: 8])
    );
  end

  assign lk_hit = lk_valid && (|lk_byte_en);

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Self-checking bench for coalescing_store_buffer: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_coalescing_store_buffer;

  localparam int DEPTH = 4;
`ifdef SB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enq_valid;
  logic [31:0] enq_addr;
  logic [31:0] enq_data;
  logic [3:0]  enq_byte_en;
  logic        enq_ready;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic [3:0]  lk_byte_en;
  logic        drain_valid;
  logic [31:0] drain_addr;
  logic [31:0] drain_data;
  logic [3:0]  drain_byte_en;
  logic        drain_ready;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        stall_pipeline;

  coalescing_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .enq_valid      (enq_valid),
    .enq_addr       (enq_addr),
    .enq_data       (enq_data),
    .enq_byte_en    (enq_byte_en),
    .enq_ready      (enq_ready),
    .lk_valid       (lk_valid),
    .lk_addr        (lk_addr),
    .lk_hit         (lk_hit),
    .lk_data        (lk_data),
    .lk_byte_en     (lk_byte_en),
    .drain_valid    (drain_valid),
    .drain_addr     (drain_addr),
    .drain_data     (drain_data),
    .drain_byte_en  (drain_byte_en),
    .drain_ready    (drain_ready),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .stall_pipeline (stall_pipeline)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: oldest entry at index 0, youngest at the back.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ment_t;
  ment_t q[$];

  function automatic int youngest(input logic [31:0] a);
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j].addr[31:2] == a[31:2]) return j;
    end
    return -1;
  endfunction

  task automatic check_model();
    logic [3:0]  mbe;
    logic [31:0] md;
    logic        mfull, mhit, mready;
    mfull  = (q.size() == DEPTH);
    mhit   = COAL && (youngest(enq_addr) > 0);
    mready = !mfull || mhit;
    mbe = '0;
    md  = '0;
    if (lk_valid) begin
      for (int b = 0; b < 4; b++) begin
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (q[j].addr[31:2] == lk_addr[31:2] && q[j].be[b]) begin
            mbe[b] = 1'b1;
            md[8*b +: 8] = q[j].data[8*b +: 8];
            break;
          end
        end
      end
    end
    chk("m.count", count, q.size());
    chk("m.full", full, mfull);
    chk("m.empty", empty, q.size() == 0);
    chk("m.enq_ready", enq_ready, mready);
    chk("m.stall", stall_pipeline, enq_valid && !mready);
    chk("m.lk_hit", lk_hit, lk_valid && (mbe != 0));
    chk("m.lk_byte_en", lk_byte_en, mbe);
    chk("m.lk_data", lk_data, md);
    chk("m.drain_valid", drain_valid, q.size() != 0);
    chk("m.drain_addr", drain_addr, (q.size() != 0) ? q[0].addr : 32'h0);
    chk("m.drain_data", drain_data, (q.size() != 0) ? q[0].data : 32'h0);
    chk("m.drain_be", drain_byte_en, (q.size() != 0) ? q[0].be : 4'h0);
  endtask

  task automatic model_update();
    int    ym;
    logic  hit, mfull, popn, pushn;
    ment_t t;
    if (!reset) begin
      q.delete();
    end else begin
      ym    = youngest(enq_addr);
      hit   = COAL && (ym > 0);
      mfull = (q.size() == DEPTH);
      popn  = (q.size() != 0) && drain_ready;
      pushn = enq_valid && !mfull && !hit && (enq_byte_en != 0);
      if (enq_valid && hit) begin
        t = q[ym];
        for (int b = 0; b < 4; b++) begin
          if (enq_byte_en[b]) t.data[8*b +: 8] = enq_data[8*b +: 8];
        end
        t.be  = t.be | enq_byte_en;
        q[ym] = t;
      end
      if (popn) void'(q.pop_front());
      if (pushn) begin
        t.addr = {enq_addr[31:2], 2'b00};
        t.data = enq_data;
        t.be   = enq_byte_en;
        q.push_back(t);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] eb, input logic lv, input logic [31:0] la, input logic dr);
    @(negedge clk);
    reset       = rst;
    enq_valid   = ev;
    enq_addr    = ea;
    enq_data    = ed;
    enq_byte_en = eb;
    lk_valid    = lv;
    lk_addr     = la;
    drain_ready = dr;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
  endtask

  task automatic cyc(input logic ev, input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb,
                     input logic lv, input logic [31:0] la, input logic dr);
    drive(1'b1, ev, ea, ed, eb, lv, la, dr);
    check_model();
    advance();
  endtask

  typedef struct {
    logic        ev;
    logic [31:0] ea;
    logic        lv;
    logic [31:0] la;
    logic        dr;
    logic [2:0]  x_count;
    logic        x_full, x_empty, x_ready, x_stall, x_hit;
    logic [31:0] x_lkd;
    logic        x_dv;
    logic [31:0] x_da;
  } vec_t;

  function automatic vec_t mkv(input logic ev, input logic [31:0] ea, input logic lv, input logic [31:0] la,
                               input logic dr, input logic [2:0] c, input logic f, input logic e,
                               input logic r, input logic s, input logic h, input logic [31:0] lkd,
                               input logic dv, input logic [31:0] da);
    vec_t v;
    v.ev = ev; v.ea = ea; v.lv = lv; v.la = la; v.dr = dr;
    v.x_count = c; v.x_full = f; v.x_empty = e; v.x_ready = r; v.x_stall = s;
    v.x_hit = h; v.x_lkd = lkd; v.x_dv = dv; v.x_da = da;
    return v;
  endfunction

  vec_t tv[10];

  initial begin
    // Fill, overflow, then in-order drain; data is 0xD000_0000 | address.
    tv[0] = mkv(1, 32'h10, 1, 32'h10, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    tv[1] = mkv(1, 32'h20, 1, 32'h10, 0, 1, 0, 0, 1, 0, 1, 32'hD000_0010, 1, 32'h10);
    tv[2] = mkv(1, 32'h30, 1, 32'h30, 0, 2, 0, 0, 1, 0, 0, 32'h0, 1, 32'h10);
    tv[3] = mkv(1, 32'h40, 1, 32'h20, 0, 3, 0, 0, 1, 0, 1, 32'hD000_0020, 1, 32'h10);
    tv[4] = mkv(1, 32'h50, 1, 32'h40, 0, 4, 1, 0, 0, 1, 1, 32'hD000_0040, 1, 32'h10);
    tv[5] = mkv(1, 32'h50, 0, 32'h0,  1, 4, 1, 0, 0, 1, 0, 32'h0, 1, 32'h10);
    tv[6] = mkv(0, 32'h0,  1, 32'h10, 1, 3, 0, 0, 1, 0, 0, 32'h0, 1, 32'h20);
    tv[7] = mkv(0, 32'h0,  1, 32'h30, 1, 2, 0, 0, 1, 0, 1, 32'hD000_0030, 1, 32'h30);
    tv[8] = mkv(0, 32'h0,  0, 32'h0,  1, 1, 0, 0, 1, 0, 0, 32'h0, 1, 32'h40);
    tv[9] = mkv(0, 32'h0,  0, 32'h0,  0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 32'h0);

    reset = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_byte_en = '0;
    lk_valid = 1'b0; lk_addr = '0; drain_ready = 1'b0;

    // Reset held for two cycles with a store pending.
    drive(1'b0, 1'b1, 32'h80, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0);
    advance();
    drive(1'b0, 1'b1, 32'h80, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0);
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h80, 1'b0);
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.drain_valid", drain_valid, 0);
    chk("rst.enq_ready", enq_ready, 1);
    chk("rst.lk_hit", lk_hit, 0);
    chk("rst.lk_data", lk_data, 0);
    chk("rst.drain_addr", drain_addr, 0);
    check_model();
    advance();

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tv[i].ev, tv[i].ea, 32'hD000_0000 | tv[i].ea, 4'hF, tv[i].lv, tv[i].la, tv[i].dr);
      chk($sformatf("tv%0d.count", i), count, tv[i].x_count);
      chk($sformatf("tv%0d.full", i), full, tv[i].x_full);
      chk($sformatf("tv%0d.empty", i), empty, tv[i].x_empty);
      chk($sformatf("tv%0d.enq_ready", i), enq_ready, tv[i].x_ready);
      chk($sformatf("tv%0d.stall", i), stall_pipeline, tv[i].x_stall);
      chk($sformatf("tv%0d.lk_hit", i), lk_hit, tv[i].x_hit);
      chk($sformatf("tv%0d.lk_data", i), lk_data, tv[i].x_lkd);
      chk($sformatf("tv%0d.drain_valid", i), drain_valid, tv[i].x_dv);
      chk($sformatf("tv%0d.drain_addr", i), drain_addr, tv[i].x_da);
      chk($sformatf("tv%0d.drain_data", i), drain_data, tv[i].x_dv ? (32'hD000_0000 | tv[i].x_da) : 32'h0);
      check_model();
      advance();
    end

    // Byte merge across two entries of the same word.
    cyc(1'b1, 32'h100, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h102, 32'hBB00_0000, 4'b1000, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h103, 1'b0);
    chk("merge.count", count, 2);
    chk("merge.lk_byte_en", lk_byte_en, 4'b1001);
    chk("merge.lk_data", lk_data, 32'hBB00_00AA);
    chk("merge.lk_hit", lk_hit, 1);
    check_model();
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h100, 1'b1);
    chk("merge.idle_lk_data", lk_data, 0);
    chk("merge.idle_lk_be", lk_byte_en, 0);
    chk("merge.drain0_data", drain_data, 32'h0000_00AA);
    chk("merge.drain0_be", drain_byte_en, 4'b0001);
    check_model();
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("merge.drain1_data", drain_data, 32'hBB00_0000);
    chk("merge.drain1_be", drain_byte_en, 4'b1000);
    check_model();
    advance();

    // Coalescing: a head match allocates, a non-head match merges.
    cyc(1'b1, 32'h200, 32'h0000_1122, 4'b0011, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h204, 32'hAAAA_AAAA, 4'b1111, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h200, 32'h5566_0000, 4'b1100, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h204, 32'h1234_5678, 4'b1111, 1'b0, 32'h0, 1'b0);
    chk("coal.count3", count, 3);
    check_model();
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("coal.count_after", count, COAL ? 3 : 4);
    chk("coal.d0_addr", drain_addr, 32'h200);
    chk("coal.d0_data", drain_data, 32'h0000_1122);
    check_model();
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("coal.d1_addr", drain_addr, 32'h204);
    chk("coal.d1_data", drain_data, COAL ? 32'h1234_5678 : 32'hAAAA_AAAA);
    check_model();
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    chk("coal.d2_addr", drain_addr, 32'h200);
    chk("coal.d2_data", drain_data, 32'h5566_0000);
    chk("coal.d2_be", drain_byte_en, 4'b1100);
    check_model();
    advance();
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    chk("coal.empty", empty, 1);
    check_model();
    advance();

    // Coalesce into a full buffer, then reset discards everything.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h300 + 32'(4 * i), 32'hD000_0300 + 32'(4 * i), 4'hF, 1'b0, 32'h0, 1'b0);
    end
    drive(1'b1, 1'b1, 32'h304, 32'h0000_0099, 4'b0001, 1'b0, 32'h0, 1'b0);
    chk("fullcoal.full", full, 1);
    chk("fullcoal.enq_ready", enq_ready, COAL);
    chk("fullcoal.stall", stall_pipeline, !COAL);
    check_model();
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h304, 1'b0);
    chk("fullcoal.count", count, 4);
    chk("fullcoal.lk_data", lk_data, COAL ? 32'hD000_0399 : 32'hD000_0304);
    check_model();
    advance();
    drive(1'b0, 1'b1, 32'h500, 32'h1, 4'hF, 1'b0, 32'h0, 1'b1);
    advance();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300, 1'b0);
    chk("midrst.count", count, 0);
    chk("midrst.empty", empty, 1);
    chk("midrst.drain_addr", drain_addr, 0);
    chk("midrst.lk_hit", lk_hit, 0);
    check_model();
    advance();

    // Wrap-around: move head to 3, then push+pop together for six cycles at count 2.
    cyc(1'b1, 32'h400, 32'hC400, 4'hF, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h404, 32'hC404, 4'hF, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h408, 32'hC408, 4'hF, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h40C, 32'hC40C, 4'hF, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h410, 32'hC410, 4'hF, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'h414 + 32'(4 * i), 32'hC414 + 32'(4 * i), 4'hF, 1'b0, 32'h0, 1'b1);
      chk($sformatf("wrap%0d.count", i), count, 2);
      chk($sformatf("wrap%0d.drain_addr", i), drain_addr, 32'h40C + 32'(4 * i));
      chk($sformatf("wrap%0d.drain_data", i), drain_data, 32'hC40C + 32'(4 * i));
      check_model();
      advance();
    end

    // Random traffic over a small set of words so matches and merges are frequent.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) < 7),
            32'h600 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
            $urandom,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 6),
            32'h600 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1));
      check_model();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coalescing_store_buffer.md
# coalescing_store_buffer

Parametrised, N-entry FIFO store buffer between the MEM-stage data cache and its drain target. Accepts store hits from the cache, forwards buffered bytes to loads with byte-granular youngest-first merging across all entries, and drains in order under a valid/ready handshake. Replaces the single-purpose store buffer in the memory stage; the depth, data width and coalescing mode are configurable.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- AW, 32: address width.
- DW, 32: data width; a multiple of 8. BE = DW/8 and OFF = log2(BE).
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low.
- enq_valid  in  1  store request. Data is already lane-aligned.
- enq_addr  in  AW  store byte address. Only the word address addr[AW-1:OFF] is used.
- enq_data  in  DW  store data.
- enq_byte_en  in  BE  byte enables. An all-zero value is legal; such an enqueue is accepted and ignored.
- enq_ready  out  1  the enqueue is accepted this cycle.
- lk_valid  in  1  load lookup.
- lk_addr  in  AW  load address.
- lk_hit  out  1  at least one requested byte was found in the buffer.
- lk_data  out  DW  merged forwarded bytes.
- lk_byte_en  out  BE  which bytes of lk_data are valid.
- drain_valid  out  1  the head entry is presented.
- drain_addr  out  AW  word-aligned address; the low OFF bits are zero.
- drain_data  out  DW  head entry data.
- drain_byte_en  out  BE  head entry byte enables.
- drain_ready  in  1  the sink accepts the head entry.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  log2(DEPTH)+1  occupancy.
- stall_pipeline  out  1  enq_valid && !enq_ready.

## Operation
- Storage is a circular array. head and tail are log2(DEPTH)-bit pointers that wrap modulo DEPTH. A per-entry valid bit is kept alongside count.
- Pop happens when drain_valid && drain_ready: the head entry is invalidated and head increments.
- Push happens when enq_valid && enq_ready and the store does not coalesce: the entry is written at tail and tail increments.
- enq_ready = !full || coalesce_hit. It depends on the current full flag only. A pop in the same cycle does not free a slot for that cycle's push.
- Simultaneous push and pop leaves count unchanged. Both pointers advance.
- Lookup is purely combinational over the registered entries. An enqueue in the same cycle is not visible to the lookup.
- For each byte b, lk_data[b] comes from the youngest valid entry whose word address matches and whose be[b] is set. lk_byte_en[b] is set exactly when such an entry exists.
- lk_hit = lk_valid && |lk_byte_en. When lk_valid is low, lk_hit, lk_byte_en and lk_data are all 0.
- The caller decides coverage: a word load needs all BE bytes, a byte load needs its own byte.
- drain_valid = !empty. The drain_* outputs show the head entry, or 0 when the buffer is empty.

## Timing
- Reset (reset == 0 at a clock edge): head, tail and count go to 0 and all valid bits clear.
- Outputs after reset: empty = 1, full = 0, drain_valid = 0, enq_ready = 1, lk_hit = 0, and lk_data, lk_byte_en and all drain_* outputs are 0.
- Reset has priority over any push, pop or coalesce in the same cycle. In-flight entries are discarded.
- A store enqueued at edge N is visible to lookup and drain from cycle N+1. Its minimum drain-out is at edge N+1.
- Pop and coalesce take effect at the same edge. A coalesce never targets the head entry, so it never races a drain.
- Full buffer with drain_ready high: the buffer still refuses a non-coalescing store, and stall_pipeline is high for that cycle.

## Configuration
- Macro: SB_COALESCE_EN.
- Defined: if the youngest valid entry with a matching word address is not the head, the store merges into it. Bytes with enq_byte_en set are overwritten, be becomes old OR new, and the pointers and count do not change. coalesce_hit asserts in this case, including when the buffer is full. If the youngest match is the head, a new entry is allocated.
- Not defined: coalesce_hit = 0, and every accepted store allocates a new entry.

## Structure
- Package sb_pkg holds:
  - the entry typedef sb_entry_t {word address, data, byte enables}, sized by AW/DW;
  - the clog2 helper;
  - the constant OFF.
- One sub-module, sb_byte_forward: per-byte youngest-first priority select over the entries, ordered by age from head. It is instantiated BE times.

## Test plan
- Reset behaviour: DEPTH=4, hold reset=0 for 2 cycles while driving enq_valid=1 -> count=0, empty=1, drain_valid=0.
- Fill to full and overflow: enqueue words 0x10, 0x20, 0x30, 0x40 with drain_ready=0 -> full=1. A fifth store to 0x50 -> enq_ready=0, stall_pipeline=1.
- Drain order: release drain_ready -> drain_addr sequence 0x10, 0x20, 0x30, 0x40 with matching data on consecutive cycles, then empty=1.
- Byte merge:
  - store 0x100 data 0x000000AA be 0001;
  - then store 0x100 data 0xBB000000 be 1000 (macro off);
  - lookup 0x100 -> lk_byte_en=1001, lk_data=0xBB0000AA, lk_hit=1.
- Coalescing (SB_COALESCE_EN): stores to 0x200 (be 0011), 0x204, then 0x200 (be 1100, data 0x55660000) -> count=3. Entry 0x200 is the head and is not merged.
  - Next, store 0x204 (be 1111) -> count stays 3.
  - Then a drained entry 0x204 shows the merged data.
- Wrap-around with simultaneous push and pop: at count=2 with head=3, push and pop in the same cycle for 6 cycles -> count stays 2, the pointers wrap, and FIFO order is preserved.
